pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 213 +++++++++++++++++++++
 tb/tb_pwm_multi.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel centre-less PWM with shared period counter, per-channel phase/duty,
// shadowed reloads and optional dead-time insertion (enable with PWM_MULTI_DEADTIME_EN).
module pwm_multi #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [CNT_W-1:0]        period_in,
    input  logic [N_CH*CNT_W-1:0]   duty_in,
    input  logic [N_CH*CNT_W-1:0]   phase_in,
    input  logic [DT_W-1:0]         dt_in,
    output logic [N_CH-1:0]         hi,
    output logic [N_CH-1:0]         lo,
    output logic                    sync,
    output logic                    load_ack
);

    localparam int unsigned PW  = CNT_W + 1;
    localparam int unsigned DW1 = DT_W + 1;

    logic [CNT_W-1:0]                  cnt;
    logic [CNT_W-1:0]                  period_q;
    logic [CNT_W-1:0]                  period_s;
    logic [N_CH-1:0][CNT_W-1:0]        duty_q;
    logic [N_CH-1:0][CNT_W-1:0]        phase_q;
    logic [N_CH-1:0][CNT_W-1:0]        duty_s;
    logic [N_CH-1:0][CNT_W-1:0]        phase_s;
    logic                              pending;

    logic                              wrap_c;
    logic                              xfer_c;
    logic [CNT_W-1:0]                  period_eff_c;
    logic [N_CH-1:0][CNT_W-1:0]        phase_eff_c;
    logic [N_CH-1:0][PW-1:0]           pos_c;
    logic [N_CH-1:0]                   raw_c;

    assign wrap_c = (cnt >= (period_q - CNT_W'(1)));
    assign xfer_c = pending & (~en | wrap_c);

    // Clamp shadow values on their way into the active set
    always_comb begin
        period_eff_c = (period_s < CNT_W'(2)) ? CNT_W'(2) : period_s;
        phase_eff_c  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            phase_eff_c[i] = (phase_s[i] >= period_eff_c) ? (period_eff_c - CNT_W'(1)) : phase_s[i];
        end
    end

    // Shadow capture, pending flag and shadow-to-active transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_s <= '0;
            duty_s   <= '0;
            phase_s  <= '0;
            pending  <= 1'b0;
            period_q <= CNT_W'(2);
            duty_q   <= '0;
            phase_q  <= '0;
            load_ack <= 1'b0;
        end else begin
            if (load) begin
                period_s <= period_in;
                duty_s   <= duty_in;
                phase_s  <= phase_in;
            end
            pending  <= load | (pending & ~xfer_c);
            load_ack <= xfer_c;
            if (xfer_c) begin
                period_q <= period_eff_c;
                duty_q   <= duty_s;
                phase_q  <= phase_eff_c;
            end
        end
    end

    // Shared period counter and start-of-period pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sync <= 1'b0;
        end else begin
            sync <= en & wrap_c;
            if (!en || wrap_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Phase-shifted position (one conditional subtract) and raw compare
    always_comb begin
        pos_c = '0;
        raw_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            pos_c[i] = PW'(cnt) + PW'(phase_q[i]);
            if (pos_c[i] >= PW'(period_q)) begin
                pos_c[i] = pos_c[i] - PW'(period_q);
            end
            raw_c[i] = (pos_c[i] < PW'(duty_q[i]));
        end
    end

`ifdef PWM_MULTI_DEADTIME_EN
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LO_ON      = 3'd1,
        DEAD_TO_HI = 3'd2,
        HI_ON      = 3'd3,
        DEAD_TO_LO = 3'd4
    } state_t;

    logic dt_zero_c;
    assign dt_zero_c = (dt_in == '0);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t           state_q;
        state_t           state_n;
        logic [DT_W-1:0]  dcnt_q;
        logic [DT_W-1:0]  dcnt_n;
        logic             dt_done_c;
        logic             hi_q;
        logic             lo_q;

        assign dt_done_c = ((DW1'(dcnt_q) + DW1'(1)) >= DW1'(dt_in));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                dcnt_q  <= '0;
                hi_q    <= 1'b0;
                lo_q    <= 1'b0;
            end else begin
                state_q <= state_n;
                dcnt_q  <= dcnt_n;
                hi_q    <= (state_n == HI_ON);
                lo_q    <= (state_n == LO_ON);
            end
        end

        // Gate-drive sequencing with dead band between the two sides
        always_comb begin
            state_n = state_q;
            dcnt_n  = dcnt_q;
            if (!en) begin
                state_n = IDLE;
                dcnt_n  = '0;
            end else begin
                case (state_q)
                    IDLE, LO_ON: begin
                        if (raw_c[g]) begin
                            state_n = dt_zero_c ? HI_ON : DEAD_TO_HI;
                            dcnt_n  = '0;
                        end else begin
                            state_n = LO_ON;
                        end
                    end
                    DEAD_TO_HI: begin
                        if (!raw_c[g]) begin
                            state_n = LO_ON;
                        end else if (dt_done_c) begin
                            state_n = HI_ON;
                        end else begin
                            dcnt_n = dcnt_q + DT_W'(1);
                        end
                    end
                    HI_ON: begin
                        if (!raw_c[g]) begin
                            state_n = dt_zero_c ? LO_ON : DEAD_TO_LO;
                            dcnt_n  = '0;
                        end
                    end
                    DEAD_TO_LO: begin
                        if (raw_c[g]) begin
                            state_n = HI_ON;
                        end else if (dt_done_c) begin
                            state_n = LO_ON;
                        end else begin
                            dcnt_n = dcnt_q + DT_W'(1);
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        assign hi[g] = hi_q;
        assign lo[g] = lo_q;
    end
`else
    // Dead-time is not built in this configuration
    logic dt_unused_c;
    assign dt_unused_c = ^dt_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (!en) begin
            hi <= '0;
            lo <= '0;
        end else begin
            hi <= raw_c;
            lo <= ~raw_c;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi: period/duty/phase, reload timing,
// clamps, enable/reset behaviour and (with PWM_MULTI_DEADTIME_EN) dead-time.
module tb_pwm_multi;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DT_W  = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   en;
    logic                   load;
    logic [CNT_W-1:0]       period_in;
    logic [N_CH*CNT_W-1:0]  duty_in;
    logic [N_CH*CNT_W-1:0]  phase_in;
    logic [DT_W-1:0]        dt_in;
    logic [N_CH-1:0]        hi;
    logic [N_CH-1:0]        lo;
    logic                   sync;
    logic                   load_ack;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [N_CH-1:0] hs [64];
    logic [N_CH-1:0] ls [64];
    logic            ss [64];
    logic            as_ [64];

    pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .period_in(period_in), .duty_in(duty_in), .phase_in(phase_in), .dt_in(dt_in),
        .hi(hi), .lo(lo), .sync(sync), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int unsigned per,
                            input int unsigned d0, input int unsigned d1,
                            input int unsigned d2, input int unsigned d3,
                            input int unsigned p0, input int unsigned p1,
                            input int unsigned p2, input int unsigned p3);
        period_in = CNT_W'(per);
        duty_in   = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
        phase_in  = {CNT_W'(p3), CNT_W'(p2), CNT_W'(p1), CNT_W'(p0)};
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_sync(input string tag);
        int n = 0;
        while (sync !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(sync), 32'd1);
    endtask

    task automatic capture(input int len);
        for (int k = 0; k < len; k++) begin
            hs[k]  = hi;
            ls[k]  = lo;
            ss[k]  = sync;
            as_[k] = load_ack;
            tick();
        end
    endtask

    // Idle, configure with en low so the transfer is immediate, then run
    task automatic restart(input int unsigned per, input int unsigned d0, input int unsigned d1,
                           input int unsigned d2, input int unsigned d3,
                           input int unsigned p0, input int unsigned p1,
                           input int unsigned p2, input int unsigned p3);
        en = 1'b0;
        tick();
        load_cfg(per, d0, d1, d2, d3, p0, p1, p2, p3);
        tick();
        en = 1'b1;
    endtask

    function automatic int count_hi(input int ch, input int from, input int to);
        int c = 0;
        for (int k = from; k <= to; k++) if (hs[k][ch] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_lo(input int ch, input int from, input int to);
        int c = 0;
        for (int k = from; k <= to; k++) if (ls[k][ch] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_sync(input int from, input int to);
        int c = 0;
        for (int k = from; k <= to; k++) if (ss[k] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_rise(input int ch, input int from, input int to);
        for (int k = from; k <= to; k++)
            if (hs[k-1][ch] === 1'b0 && hs[k][ch] === 1'b1) return k;
        return -1;
    endfunction

    function automatic int first_ack(input int len);
        for (int k = 0; k < len; k++) if (as_[k] === 1'b1) return k;
        return -1;
    endfunction

    function automatic int count_ack(input int len);
        int c = 0;
        for (int k = 0; k < len; k++) if (as_[k] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_overlap(input int len);
        int c = 0;
        for (int k = 0; k < len; k++) if ((hs[k] & ls[k]) != '0) c++;
        return c;
    endfunction

    function automatic int count_lo_not_inv(input int len);
        int c = 0;
        for (int k = 0; k < len; k++) if (ls[k] !== ~hs[k]) c++;
        return c;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        period_in = '0; duty_in = '0; phase_in = '0; dt_in = '0;
        repeat (2) tick();
        check("reset_hi", 32'(hi), 32'd0);
        check("reset_lo", 32'(lo), 32'd0);
        check("reset_sync", 32'(sync), 32'd0);
        check("reset_ack", 32'(load_ack), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic run plus duty/phase boundaries, period 10
        load_cfg(10, 5, 0, 10, 3, 0, 0, 0, 15);
        check("ack_before_xfer", 32'(load_ack), 32'd0);
        tick();
        check("ack_en0_xfer", 32'(load_ack), 32'd1);
        tick();
        check("ack_one_cycle", 32'(load_ack), 32'd0);
        en = 1'b1;
        wait_sync("t1_sync_seen");
        capture(20);
        check("t1_sync_at10", 32'(ss[10]), 32'd1);
        check("t1_sync_count", 32'(count_sync(0, 19)), 32'd2);
        check("t1_hi0_high", 32'(count_hi(0, 0, 9)), 32'd5);
        check("t1_hi0_rise", 32'(first_rise(0, 1, 19)), 32'd1);
        check("t1_lo_inv_hi", 32'(count_lo_not_inv(20)), 32'd0);
        check("t1_duty_zero", 32'(count_hi(1, 0, 19)), 32'd0);
        check("t1_duty_full", 32'(count_hi(2, 0, 19)), 32'd20);
        check("t1_phase_clamp_high", 32'(count_hi(3, 0, 9)), 32'd3);
        check("t1_phase_clamp_rise", 32'(first_rise(3, 1, 19)), 32'd2);
        check("t1_overlap", 32'(count_overlap(20)), 32'd0);

        // Staggered phases, period 12
        restart(12, 6, 6, 6, 6, 0, 3, 6, 9);
        wait_sync("t2_sync_seen");
        capture(26);
        check("t2_sync_at12", 32'(ss[12]), 32'd1);
        check("t2_rise_ch0", 32'(first_rise(0, 1, 25)), 32'd1);
        check("t2_rise_ch1", 32'(first_rise(1, 1, 25)), 32'd10);
        check("t2_rise_ch2", 32'(first_rise(2, 1, 25)), 32'd7);
        check("t2_rise_ch3", 32'(first_rise(3, 1, 25)), 32'd4);

        // Reload mid-period while running: old period finishes, then period 8
        restart(10, 5, 0, 0, 0, 0, 0, 0, 0);
        wait_sync("t3_sync_seen");
        repeat (3) tick();
        load_cfg(8, 5, 0, 0, 0, 0, 0, 0, 0);
        capture(20);
        check("t3_ack_index", 32'(first_ack(20)), 32'd6);
        check("t3_ack_count", 32'(count_ack(20)), 32'd1);
        check("t3_sync_old_end", 32'(ss[6]), 32'd1);
        check("t3_sync_new_period", 32'(ss[14]), 32'd1);
        check("t3_sync_count", 32'(count_sync(0, 19)), 32'd2);
        check("t3_hi0_new_high", 32'(count_hi(0, 6, 13)), 32'd5);

        // period_in=1 is clamped to 2
        restart(1, 1, 0, 0, 0, 0, 0, 0, 0);
        wait_sync("t4_sync_seen");
        capture(8);
        check("t4_sync_at2", 32'(ss[2]), 32'd1);
        check("t4_sync_count", 32'(count_sync(0, 7)), 32'd4);
        check("t4_hi0_high", 32'(count_hi(0, 0, 7)), 32'd4);

        // Drop en mid-period, then restart from cnt=0
        restart(10, 5, 0, 0, 0, 0, 0, 0, 0);
        wait_sync("t5_sync_seen");
        repeat (2) tick();
        check("t5_pre_hi0", 32'(hi[0]), 32'd1);
        en = 1'b0;
        tick();
        check("t5_off_hi", 32'(hi), 32'd0);
        check("t5_off_lo", 32'(lo), 32'd0);
        check("t5_off_sync", 32'(sync), 32'd0);
        en = 1'b1;
        tick();
        check("t5_restart_hi0", 32'(hi[0]), 32'd1);
        n = 1;
        while (sync !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("t5_restart_sync_delay", 32'(n), 32'd10);

        // Async reset mid-period clears outputs without a clock edge
        wait_sync("t6_sync_seen");
        repeat (2) tick();
        check("t6_pre_hi0", 32'(hi[0]), 32'd1);
        rst_n = 1'b0;
        #2;
        check("t6_rst_hi", 32'(hi), 32'd0);
        check("t6_rst_lo", 32'(lo), 32'd0);
        check("t6_rst_sync", 32'(sync), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_sync("t6_post_sync_seen");
        capture(6);
        check("t6_period2_sync2", 32'(ss[2]), 32'd1);
        check("t6_period2_sync4", 32'(ss[4]), 32'd1);
        check("t6_duty_reset_hi", 32'(count_hi(0, 0, 5)), 32'd0);
        check("t6_duty_reset_lo", 32'(count_lo(0, 0, 5)), 32'd6);

`ifdef PWM_MULTI_DEADTIME_EN
        // Dead-time of 2 cycles on a 20-cycle, 50% waveform
        dt_in = DT_W'(2);
        restart(20, 10, 0, 0, 0, 0, 0, 0, 0);
        wait_sync("t7_sync_seen");
        capture(20);
        check("t7_hi0_high", 32'(count_hi(0, 0, 19)), 32'd8);
        check("t7_lo0_high", 32'(count_lo(0, 0, 19)), 32'd8);
        check("t7_hi0_rise", 32'(first_rise(0, 1, 19)), 32'd3);
        check("t7_overlap", 32'(count_overlap(20)), 32'd0);
        repeat (11) tick();
        check("t7_dead_hi0", 32'(hi[0]), 32'd0);
        check("t7_dead_lo0", 32'(lo[0]), 32'd0);
        en = 1'b0;
        tick();
        check("t7_en_off_hi", 32'(hi), 32'd0);
        check("t7_en_off_lo", 32'(lo), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
